// File: rtl/control_unit_pkg.sv
// Shared constants for the multi-cycle control unit:
// state encoding, decoder TYPE_* one-hot indices and GROUP_* bits.
package control_unit_pkg;

  localparam int STATE_WIDTH  = 3;
  localparam int OPCODE_COUNT = 12;
  localparam int GROUP_COUNT  = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // opcode_type is one-hot; these are bit positions
  localparam int TYPE_UNKNOWN = 0;
  localparam int TYPE_NOP     = 1;
  localparam int TYPE_ADD     = 2;
  localparam int TYPE_ADC     = 3;
  localparam int TYPE_SUB     = 4;
  localparam int TYPE_SBC     = 5;
  localparam int TYPE_AND     = 6;
  localparam int TYPE_OR      = 7;
  localparam int TYPE_EOR     = 8;
  localparam int TYPE_NEG     = 9;
  localparam int TYPE_COM     = 10;
  localparam int TYPE_MOV     = 11;

  localparam int GROUP_ALU        = 0;
  localparam int GROUP_ALU_TWO_OP = 1;

  // A NOP is only accepted as a clean one-hot code;
  // stray extra type bits fall through to illegal.
  function automatic logic is_nop(
    input logic [OPCODE_COUNT-1:0] t
  );
    return t == (OPCODE_COUNT'(1) << TYPE_NOP);
  endfunction

endpackage

// File: rtl/control_unit_retire_counter.sv
// Retired-instruction counter, wraps all-ones -> 0.
// Ports: clk_i, rst_ni (async low), inc_i, cnt_o.
module control_unit_retire_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/control_unit.sv
// FETCH -> DECODE -> EXEC -> WB sequencer with halt and retire count.
// In: clk, reset(async low), fetch_ack, opcode_type/group, halt_req.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_ack,
  input  logic [OPCODE_COUNT-1:0] opcode_type,
  input  logic [GROUP_COUNT-1:0]  opcode_group,
  input  logic                    halt_req,
  output logic                    fetch_req,
  output logic                    ir_load,
  output logic                    pc_inc,
  output logic                    rf_rd_en,
  output logic                    rf_rd_two,
  output logic                    alu_en,
  output logic                    rf_wr_en,
  output logic                    sreg_wr,
  output logic                    illegal,
  output logic                    halted,
  output logic [CNT_WIDTH-1:0]    retired_cnt,
  output logic [STATE_WIDTH-1:0]  state
);

  state_e state_q;
  state_e state_d;
  state_e boundary;
  logic   retire;

  // halt_req only matters when an instruction has finished
  assign boundary = halt_req ? S_HALT : S_FETCH;

  always_comb begin
    state_d   = S_FETCH;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    rf_rd_en  = 1'b0;
    rf_rd_two = 1'b0;
    alu_en    = 1'b0;
    rf_wr_en  = 1'b0;
    sreg_wr   = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      S_RESET: begin
        state_d = boundary;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (opcode_group[GROUP_ALU]) begin
          rf_rd_en  = 1'b1;
          rf_rd_two = opcode_group[GROUP_ALU_TWO_OP];
          state_d   = S_EXEC;
        end else begin
          retire  = is_nop(opcode_type);
          illegal = !is_nop(opcode_type);
          state_d = boundary;
        end
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        rf_wr_en = 1'b1;
        sreg_wr  = 1'b1;
        retire   = 1'b1;
        state_d  = boundary;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  assign state = state_q;

  control_unit_retire_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_retire_counter (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (retire),
    .cnt_o  (retired_cnt)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit.
// Each step carries stimulus plus expected outputs/state.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam logic [9:0] FR  = 10'h200;
  localparam logic [9:0] IL  = 10'h100;
  localparam logic [9:0] PI  = 10'h080;
  localparam logic [9:0] RD  = 10'h040;
  localparam logic [9:0] TWO = 10'h020;
  localparam logic [9:0] ALU = 10'h010;
  localparam logic [9:0] WR  = 10'h008;
  localparam logic [9:0] SR  = 10'h004;
  localparam logic [9:0] ILL = 10'h002;
  localparam logic [9:0] HLT = 10'h001;

  localparam logic [15:0] I_ADD = 16'h0C01;
  localparam logic [15:0] I_NEG = 16'h9401;
  localparam logic [15:0] I_NOP = 16'h0000;
  localparam logic [15:0] I_BAD = 16'hFFFF;

  function automatic logic [OPCODE_COUNT-1:0] dec_type(
    input logic [15:0] w
  );
    logic [OPCODE_COUNT-1:0] t;
    t = '0;
    if (w == 16'h0000)
      t[TYPE_NOP] = 1'b1;
    else if (w[15:10] == 6'b000011)
      t[TYPE_ADD] = 1'b1;
    else if (w[15:9] == 7'b1001010 && w[3:0] == 4'h1)
      t[TYPE_NEG] = 1'b1;
    else
      t[TYPE_UNKNOWN] = 1'b1;
    return t;
  endfunction

  function automatic logic [GROUP_COUNT-1:0] dec_group(
    input logic [15:0] w
  );
    logic [GROUP_COUNT-1:0] g;
    g = '0;
    if (w[15:10] == 6'b000011) begin
      g[GROUP_ALU]        = 1'b1;
      g[GROUP_ALU_TWO_OP] = 1'b1;
    end else if (w[15:9] == 7'b1001010 && w[3:0] == 4'h1) begin
      g[GROUP_ALU] = 1'b1;
    end
    return g;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fetch_ack;
  logic        halt_req;
  logic [15:0] ir;

  logic [OPCODE_COUNT-1:0] opcode_type;
  logic [GROUP_COUNT-1:0]  opcode_group;
  assign opcode_type  = dec_type(ir);
  assign opcode_group = dec_group(ir);

  logic fetch_req, ir_load, pc_inc, rf_rd_en, rf_rd_two;
  logic alu_en, rf_wr_en, sreg_wr, illegal, halted;
  logic [15:0]            retired_cnt;
  logic [STATE_WIDTH-1:0] state;

  logic w_fetch_req, w_ir_load, w_pc_inc, w_rf_rd_en, w_rf_rd_two;
  logic w_alu_en, w_rf_wr_en, w_sreg_wr, w_illegal, w_halted;
  logic [3:0]             w_cnt;
  logic [STATE_WIDTH-1:0] w_state;

  control_unit #(.CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_ack    (fetch_ack),
    .opcode_type  (opcode_type),
    .opcode_group (opcode_group),
    .halt_req     (halt_req),
    .fetch_req    (fetch_req),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_two    (rf_rd_two),
    .alu_en       (alu_en),
    .rf_wr_en     (rf_wr_en),
    .sreg_wr      (sreg_wr),
    .illegal      (illegal),
    .halted       (halted),
    .retired_cnt  (retired_cnt),
    .state        (state)
  );

  // narrow-counter copy to reach the all-ones wrap quickly
  control_unit #(.CNT_WIDTH(4)) dut_w (
    .clk          (clk),
    .reset        (reset),
    .fetch_ack    (fetch_ack),
    .opcode_type  (opcode_type),
    .opcode_group (opcode_group),
    .halt_req     (halt_req),
    .fetch_req    (w_fetch_req),
    .ir_load      (w_ir_load),
    .pc_inc       (w_pc_inc),
    .rf_rd_en     (w_rf_rd_en),
    .rf_rd_two    (w_rf_rd_two),
    .alu_en       (w_alu_en),
    .rf_wr_en     (w_rf_wr_en),
    .sreg_wr      (w_sreg_wr),
    .illegal      (w_illegal),
    .halted       (w_halted),
    .retired_cnt  (w_cnt),
    .state        (w_state)
  );

  logic [9:0] ctl_w;
  assign ctl_w = {fetch_req, ir_load, pc_inc, rf_rd_en, rf_rd_two,
                  alu_en, rf_wr_en, sreg_wr, illegal, halted};

  logic [9:0] wctl_w;
  assign wctl_w = {w_fetch_req, w_ir_load, w_pc_inc, w_rf_rd_en,
                   w_rf_rd_two, w_alu_en, w_rf_wr_en, w_sreg_wr,
                   w_illegal, w_halted};

  typedef struct {
    logic [15:0]            ir;
    logic                   ack;
    logic                   halt;
    logic [STATE_WIDTH-1:0] st;
    logic [9:0]             ctl;
    string                  tag;
  } step_t;

  step_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic push(input logic [15:0] w, input logic a,
                      input logic h, input state_e s,
                      input logic [9:0] c, input string tag);
    step_t e;
    e.ir = w; e.ack = a; e.halt = h;
    e.st = s; e.ctl = c; e.tag = tag;
    sb.push_back(e);
  endtask

  // hx: hold halt_req high from EXEC onward (ALU ops)
  task automatic push_instr(input logic [15:0] w, input int waits,
                            input logic hx, input string nm);
    logic [GROUP_COUNT-1:0] g;
    g = dec_group(w);
    for (int i = 0; i < waits; i++)
      push(w, 1'b0, 1'b0, S_FETCH, FR, {nm, " wait"});
    push(w, 1'b1, 1'b0, S_FETCH, FR | IL | PI, {nm, " fetch"});
    if (g[GROUP_ALU]) begin
      push(w, 1'b1, 1'b0, S_DECODE,
           RD | (g[GROUP_ALU_TWO_OP] ? TWO : 10'h000),
           {nm, " decode"});
      push(w, 1'b1, hx, S_EXEC, ALU, {nm, " exec"});
      push(w, 1'b1, hx, S_WB, WR | SR, {nm, " wb"});
    end else if (w == 16'h0000) begin
      push(w, 1'b1, 1'b0, S_DECODE, 10'h000, {nm, " decode"});
    end else begin
      push(w, 1'b1, 1'b0, S_DECODE, ILL, {nm, " decode"});
    end
  endtask

  task automatic drain();
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      ir        = s.ir;
      fetch_ack = s.ack;
      halt_req  = s.halt;
      #1;
      check({s.tag, " ctl"}, 32'(ctl_w), 32'(s.ctl));
      check({s.tag, " state"}, 32'(state), 32'(s.st));
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; fetch_ack = 1'b0; halt_req = 1'b0; ir = 16'h0;
    #2;
    check("reset ctl", 32'(ctl_w), 32'h0);
    check("reset state", 32'(state), 32'(S_RESET));
    check("reset cnt", 32'(retired_cnt), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    push(I_ADD, 1'b1, 1'b0, S_RESET, 10'h000, "rst cycle");
    push_instr(I_ADD, 0, 1'b0, "add");
    drain();
    check("cnt after add", 32'(retired_cnt), 32'd1);

    push_instr(I_NEG, 0, 1'b0, "neg");
    drain();
    check("cnt after neg", 32'(retired_cnt), 32'd2);

    for (int i = 0; i < 3; i++) push_instr(I_NOP, 0, 1'b0, "nop");
    drain();
    check("cnt after 3 nop", 32'(retired_cnt), 32'd5);

    push_instr(I_BAD, 0, 1'b0, "bad");
    drain();
    check("cnt after illegal", 32'(retired_cnt), 32'd5);

    push_instr(I_ADD, 5, 1'b0, "wadd");
    drain();
    check("cnt after wait add", 32'(retired_cnt), 32'd6);

    push_instr(I_ADD, 0, 1'b1, "hadd");
    push(I_NOP, 1'b1, 1'b1, S_HALT, HLT, "halt0");
    push(I_NOP, 1'b1, 1'b1, S_HALT, HLT, "halt1");
    push(I_NOP, 1'b0, 1'b0, S_HALT, HLT, "unhalt");
    push_instr(I_NOP, 1, 1'b0, "resume");
    drain();
    check("cnt after halt", 32'(retired_cnt), 32'd8);

    push(I_ADD, 1'b1, 1'b0, S_FETCH, FR | IL | PI, "radd fetch");
    push(I_ADD, 1'b1, 1'b0, S_DECODE, RD | TWO, "radd decode");
    drain();
    #1;
    check("radd exec ctl", 32'(ctl_w), 32'(ALU));
    check("radd exec state", 32'(state), 32'(S_EXEC));
    reset = 1'b0;
    #1;
    check("mid rst ctl", 32'(ctl_w), 32'h0);
    check("mid rst state", 32'(state), 32'(S_RESET));
    check("mid rst cnt", 32'(retired_cnt), 32'd0);
    @(negedge clk);
    #1;
    check("held rst ctl", 32'(ctl_w), 32'h0);
    check("held rst cnt", 32'(retired_cnt), 32'd0);
    reset = 1'b1;
    push(I_NOP, 1'b1, 1'b0, S_RESET, 10'h000, "rst2 cycle");
    push_instr(I_NOP, 0, 1'b0, "nop2");
    drain();
    check("cnt after rst", 32'(retired_cnt), 32'd1);

    for (int i = 0; i < 14; i++) push_instr(I_NOP, 0, 1'b0, "fill");
    drain();
    check("cnt 15", 32'(retired_cnt), 32'd15);
    check("wcnt all-ones", 32'(w_cnt), 32'hF);
    check("wctl idle fetch", 32'(wctl_w), 32'(FR | IL | PI));

    push_instr(I_NOP, 0, 1'b0, "wrap");
    drain();
    check("cnt 16", 32'(retired_cnt), 32'd16);
    check("wcnt wrap", 32'(w_cnt), 32'h0);
    check("wstate", 32'(w_state), 32'(S_FETCH));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
